// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester byte streams plus UART transmitter handshake for uart_tx_arbiter.
interface uart_tx_arbiter_if;
  logic [2:0] reqValid;
  logic [23:0] reqData;
  logic [2:0] reqLast;
  logic [2:0] reqReady;
  logic txBusy;
  logic txDone;
  logic txStart;
  logic [7:0] txData;
  logic [2:0] grant;
  logic [15:0] frameCount;
  logic abortPulse;
  modport master(
    output reqValid, reqData, reqLast, txBusy, txDone,
    input reqReady, txStart, txData, grant, frameCount, abortPulse
  );
  modport slave(
    input reqValid, reqData, reqLast, txBusy, txDone,
    output reqReady, txStart, txData, grant, frameCount, abortPulse
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin framer of three byte streams onto one UART, header HDR_BASE+owner per frame.
// Define ARB_TIMEOUT_EN to add the owner-stall watchdog that aborts a frame after TIMEOUT_CYCLES idle cycles.
module uart_tx_arbiter #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50000,
  parameter logic [7:0] HDR_BASE = 8'hA0
) (
  input logic clk_50,
  input logic reset,
  uart_tx_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SEND_HDR, WAIT_HDR, SEND_DATA, WAIT_DATA} state_t;
  state_t state;
  logic [1:0] rrPtr, owner, pick, cand1, cand2;
  logic lastFlag, txStart, ownerValid;
  logic [7:0] txData, ownerData;
  logic [2:0] reqReady, grant;
  logic [15:0] frameCount;
`ifdef ARB_TIMEOUT_EN
  logic [31:0] stallCount;
  logic abortPulse;
`endif
  function automatic logic [1:0] nextIdx(input logic [1:0] i);
    return i == 2'd2 ? 2'd0 : i + 2'd1;
  endfunction
  always_comb begin
    cand1 = nextIdx(rrPtr);
    cand2 = nextIdx(cand1);
    pick = bus.reqValid[rrPtr] ? rrPtr : bus.reqValid[cand1] ? cand1 : cand2;
    ownerValid = bus.reqValid[owner];
    ownerData = bus.reqData[{owner, 3'b000} +: 8];
  end
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rrPtr <= 2'd0;
      owner <= 2'd0;
      grant <= 3'd0;
      txStart <= 1'b0;
      txData <= 8'd0;
      reqReady <= 3'd0;
      frameCount <= 16'd0;
      lastFlag <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      stallCount <= 32'd0;
      abortPulse <= 1'b0;
`endif
    end else begin
      txStart <= 1'b0;
      reqReady <= 3'd0;
`ifdef ARB_TIMEOUT_EN
      abortPulse <= 1'b0;
`endif
      case (state)
        IDLE: if (|bus.reqValid) begin
          owner <= pick;
          grant <= 3'b001 << pick;
          state <= SEND_HDR;
        end
        SEND_HDR: if (!bus.txBusy) begin
          txStart <= 1'b1;
          txData <= HDR_BASE + {6'd0, owner};
          state <= WAIT_HDR;
        end
        WAIT_HDR: if (bus.txDone) state <= SEND_DATA;
        SEND_DATA: begin
          if (ownerValid && !bus.txBusy) begin
            txStart <= 1'b1;
            reqReady <= grant;
            txData <= ownerData;
            lastFlag <= bus.reqLast[owner];
            state <= WAIT_DATA;
          end
`ifdef ARB_TIMEOUT_EN
          // only consecutive cycles without owner data count towards the abort
          if (ownerValid) stallCount <= 32'd0;
          else if (stallCount == TIMEOUT_CYCLES - 32'd1) begin
            stallCount <= 32'd0;
            abortPulse <= 1'b1;
            grant <= 3'd0;
            rrPtr <= nextIdx(owner);
            state <= IDLE;
          end else stallCount <= stallCount + 32'd1;
`endif
        end
        WAIT_DATA: if (bus.txDone) begin
          state <= lastFlag ? IDLE : SEND_DATA;
          if (lastFlag) begin
            frameCount <= frameCount + 16'd1;
            grant <= 3'd0;
            rrPtr <= nextIdx(owner);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.txStart = txStart;
  assign bus.txData = txData;
  assign bus.reqReady = reqReady;
  assign bus.grant = grant;
  assign bus.frameCount = frameCount;
`ifdef ARB_TIMEOUT_EN
  assign bus.abortPulse = abortPulse;
`else
  assign bus.abortPulse = 1'b0 & (TIMEOUT_CYCLES != 32'd0);
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboarded directed bench; expected UART bytes queued at stimulus, checked on each txStart.
module tb_uart_tx_arbiter;
  logic clk_50 = 1'b0;
  logic reset = 1'b1;
  logic modelBusy = 1'b0, forceBusy = 1'b0, txDoneR = 1'b0;
  int uartCnt = 0, startCnt = 0, abortCnt = 0, nAssert = 0, nFail = 0;
  int readyCnt[3] = '{0, 0, 0};
  logic [8:0] rq[3][$];
  logic [7:0] expQ[$];
  uart_tx_arbiter_if bus();
  uart_tx_arbiter #(.TIMEOUT_CYCLES(32'd100), .HDR_BASE(8'hA0)) dut (
    .clk_50(clk_50),
    .reset(reset),
    .bus(bus)
  );
  always #10 clk_50 = ~clk_50;
  assign bus.txBusy = modelBusy | forceBusy;
  assign bus.txDone = txDoneR;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    end
  endtask
  // monitor: every launched byte must match the head of the scoreboard
  initial forever begin
    @(negedge clk_50);
    if (bus.abortPulse) abortCnt++;
    if (bus.txStart) begin
      startCnt++;
      if (expQ.size() == 0) begin
        nAssert++;
        nFail++;
        $display("FAIL unexpected txStart: got 0x%0h, wanted no byte", bus.txData);
      end else check("txData", {24'd0, bus.txData}, {24'd0, expQ.pop_front()});
    end
  end
  // UART model: busy for 10 cycles after each txStart, then one txDone pulse
  initial forever begin
    @(negedge clk_50);
    txDoneR = 1'b0;
    if (reset) begin
      uartCnt = 0;
      modelBusy = 1'b0;
    end else begin
      if (uartCnt > 0) begin
        uartCnt--;
        if (uartCnt == 0) begin
          txDoneR = 1'b1;
          modelBusy = 1'b0;
        end
      end
      if (bus.txStart) begin
        check("start while busy", {31'd0, modelBusy}, 32'd0);
        modelBusy = 1'b1;
        uartCnt = 10;
      end
    end
  end
  // requesters: present queue head, pop on reqReady
  initial begin
    bus.reqValid = 3'd0;
    bus.reqData = 24'd0;
    bus.reqLast = 3'd0;
    forever begin
      @(negedge clk_50);
      for (int i = 0; i < 3; i++) begin
        if (reset) rq[i].delete();
        else if (bus.reqReady[i]) begin
          readyCnt[i]++;
          if (rq[i].size() > 0) void'(rq[i].pop_front());
        end
        bus.reqValid[i] = rq[i].size() > 0;
        bus.reqLast[i] = rq[i].size() > 0 ? rq[i][0][8] : 1'b0;
        bus.reqData[i*8 +: 8] = rq[i].size() > 0 ? rq[i][0][7:0] : 8'h00;
      end
    end
  end
  task automatic waitDone(input string name, input int budget);
    int n = 0;
    while ((expQ.size() != 0 || rq[0].size() != 0 || rq[1].size() != 0 || rq[2].size() != 0 || bus.grant != 3'd0) && n < budget) begin
      @(negedge clk_50);
      n++;
    end
    check({name, " finished in budget"}, {31'd0, n < budget}, 32'd1);
  endtask
  task automatic checkCleared(input string name);
    check({name, " grant"}, {29'd0, bus.grant}, 32'd0);
    check({name, " txStart"}, {31'd0, bus.txStart}, 32'd0);
    check({name, " txData"}, {24'd0, bus.txData}, 32'd0);
    check({name, " reqReady"}, {29'd0, bus.reqReady}, 32'd0);
    check({name, " frameCount"}, {16'd0, bus.frameCount}, 32'd0);
    check({name, " abortPulse"}, {31'd0, bus.abortPulse}, 32'd0);
  endtask
  task automatic pulseReset();
    @(negedge clk_50);
    reset = 1'b1;
    repeat (2) @(negedge clk_50);
    reset = 1'b0;
  endtask
  initial begin
    int s, r, n;
    repeat (3) @(negedge clk_50);
    checkCleared("reset");
    reset = 1'b0;
    // single two-byte frame from requester 1
    @(negedge clk_50);
    expQ = '{8'hA1, 8'h11, 8'h22};
    rq[1].push_back(9'h011);
    rq[1].push_back(9'h122);
    waitDone("req1 frame", 200);
    check("req1 frameCount", {16'd0, bus.frameCount}, 32'd1);
    check("req1 grant", {29'd0, bus.grant}, 32'd0);
    check("req1 reqReady pulses", readyCnt[1], 32'd2);
    // all three at once right after reset
    pulseReset();
    expQ = '{8'hA0, 8'h30, 8'hA1, 8'h31, 8'hA2, 8'h32};
    rq[0].push_back(9'h130);
    rq[1].push_back(9'h131);
    rq[2].push_back(9'h132);
    waitDone("three-way", 400);
    check("three-way frameCount", {16'd0, bus.frameCount}, 32'd3);
    // req0 back-to-back frames while req2 waits
    @(negedge clk_50);
    expQ = '{8'hA0, 8'h40, 8'hA2, 8'h42, 8'hA0, 8'h41};
    rq[0].push_back(9'h140);
    rq[0].push_back(9'h141);
    rq[2].push_back(9'h142);
    waitDone("fairness", 400);
    check("fairness frameCount", {16'd0, bus.frameCount}, 32'd6);
    // transmitter busy during the header
    @(negedge clk_50);
    forceBusy = 1'b1;
    s = startCnt;
    expQ = '{8'hA1, 8'h55};
    rq[1].push_back(9'h155);
    repeat (50) @(negedge clk_50);
    check("busy holdoff starts", startCnt - s, 32'd0);
    check("busy holdoff grant", {29'd0, bus.grant}, 32'd2);
    forceBusy = 1'b0;
    waitDone("busy holdoff", 200);
    check("busy holdoff start count", startCnt - s, 32'd2);
    check("busy holdoff frameCount", {16'd0, bus.frameCount}, 32'd7);
    // owner stalls after its first byte
    @(negedge clk_50);
    expQ = '{8'hA0, 8'h60};
    rq[0].push_back(9'h060);
    repeat (150) @(negedge clk_50);
    check("stall bytes sent", expQ.size(), 32'd0);
    check("stall frameCount", {16'd0, bus.frameCount}, 32'd7);
`ifdef ARB_TIMEOUT_EN
    check("stall abort count", abortCnt, 32'd1);
    check("stall grant cleared", {29'd0, bus.grant}, 32'd0);
`else
    check("stall abort count", abortCnt, 32'd0);
    check("stall grant held", {29'd0, bus.grant}, 32'd1);
    expQ.push_back(8'h61);
    rq[0].push_back(9'h161);
    waitDone("stall resume", 200);
    check("stall resume frameCount", {16'd0, bus.frameCount}, 32'd8);
`endif
    // asynchronous reset while waiting for a data byte to finish
    @(negedge clk_50);
    r = readyCnt[0];
    expQ = '{8'hA0, 8'h55};
    rq[0].push_back(9'h055);
    rq[0].push_back(9'h166);
    n = 0;
    while (readyCnt[0] == r && n < 100) begin
      @(negedge clk_50);
      n++;
    end
    check("reset test byte accepted", {31'd0, n < 100}, 32'd1);
    repeat (3) @(negedge clk_50);
    #3 reset = 1'b1;
    #1 checkCleared("async reset");
    repeat (3) @(negedge clk_50);
    reset = 1'b0;
    check("reset drops queued bytes", expQ.size(), 32'd0);
    expQ = '{8'hA2, 8'h77};
    rq[2].push_back(9'h177);
    waitDone("post-reset", 200);
    check("post-reset frameCount", {16'd0, bus.frameCount}, 32'd1);
    check("post-reset grant", {29'd0, bus.grant}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, wanted end of test");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 32'd50000, meaning the owner-stall limit in clk_50 cycles (1 ms).
REQ-002 SHALL have parameter HDR_BASE, default 8'hA0, meaning the frame header base; header byte = HDR_BASE + requester index.
REQ-003 clk_50  input  1  sole clock; all logic is posedge clk_50.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 reqValid  input  3  per-requester byte valid; bit i belongs to requester i.
REQ-006 reqData  input  24  per-requester byte; requester i uses [8i+7:8i].
REQ-007 reqLast  input  3  per-requester last-byte-of-frame flag, qualified by reqValid.
REQ-008 reqReady  output  3  one-cycle byte-accept pulse to the owning requester.
REQ-009 txBusy  input  1  UART transmitter busy.
REQ-010 txDone  input  1  one-cycle pulse from the UART transmitter: byte finished.
REQ-011 txStart  output  1  one-cycle pulse launching txData.
REQ-012 txData  output  8  byte to transmit, valid while txStart is high.
REQ-013 grant  output  3  one-hot current owner; all zeros when idle.
REQ-014 frameCount  output  16  completed-frame counter.
REQ-015 abortPulse  output  1  one-cycle pulse on frame abort.

Function
REQ-016 SHALL implement FSM states IDLE, SEND_HDR, WAIT_HDR, SEND_DATA, WAIT_DATA.
REQ-017 IDLE: when any reqValid bit is set, SHALL pick the owner round-robin starting at pointer rrPtr, latch grant, and go to SEND_HDR the next cycle.
REQ-018 SEND_HDR: when txBusy==0, SHALL pulse txStart with txData=HDR_BASE+owner, then go to WAIT_HDR.
REQ-019 WAIT_HDR: on txDone, SHALL go to SEND_DATA.
REQ-020 SEND_DATA: when reqValid[owner]==1 and txBusy==0, SHALL pulse txStart and reqReady[owner] in the same cycle, with txData=reqData of the owner.
REQ-021 SEND_DATA: SHALL latch reqLast[owner] on that cycle, then go to WAIT_DATA.
REQ-022 WAIT_DATA: on txDone with the latched last flag set, SHALL go to IDLE, increment frameCount, clear grant, and set rrPtr=(owner+1) mod 3.
REQ-023 WAIT_DATA: on txDone with the latched last flag clear, SHALL go to SEND_DATA.
REQ-024 SHALL never pulse txStart twice without an intervening txDone; txDone seen outside WAIT_HDR/WAIT_DATA SHALL be ignored.
REQ-025 Requests from non-owners SHALL be ignored until the owner's frame ends; grant SHALL NOT change mid-frame.
REQ-026 A new request present in the cycle the FSM returns to IDLE SHALL be arbitrated in the following cycle (one idle cycle minimum between frames).
REQ-027 frameCount SHALL wrap from 16'hFFFF to 0.
REQ-028 An owner deasserting reqValid mid-frame SHALL stall SEND_DATA, without aborting unless the feature in REQ-032 is compiled in.

Reset
REQ-029 On reset, SHALL asynchronously force: state=IDLE, rrPtr=0, grant=0, txStart=0, txData=0, reqReady=0, frameCount=0, abortPulse=0, stall counter=0.
REQ-030 Reset mid-frame SHALL abandon the frame without a completion count; after release, arbitration SHALL restart from requester 0.

Configuration
REQ-031 Macro ARB_TIMEOUT_EN SHALL compile the owner-stall watchdog in or out.
REQ-032 With ARB_TIMEOUT_EN: a 32-bit counter SHALL count consecutive SEND_DATA cycles with reqValid[owner]==0.
REQ-033 With ARB_TIMEOUT_EN: when the counter reaches TIMEOUT_CYCLES, the block SHALL pulse abortPulse, go to IDLE, clear grant, advance rrPtr, and leave frameCount unchanged.
REQ-034 With ARB_TIMEOUT_EN: the counter SHALL clear on any accepted byte and on leaving SEND_DATA.
REQ-035 Without ARB_TIMEOUT_EN: abortPulse SHALL be tied 0, no counter SHALL exist, and SEND_DATA SHALL wait indefinitely.

Verification
REQ-036 Req1 sends 2 bytes 0x11,0x22 (last on 0x22), txDone 10 cycles after each txStart -> tx sequence 0xA1,0x11,0x22; reqReady[1] pulses twice; frameCount=1; grant returns 0.
REQ-037 All three request simultaneously after reset, 1-byte frames -> headers in order 0xA0,0xA1,0xA2; each frame completes before the next header.
REQ-038 Req0 frames back-to-back with req2 pending -> req2 is served after req0's frame; req0 is not granted twice in a row.
REQ-039 txBusy held high 50 cycles in SEND_HDR -> txStart is held off, then fires exactly once after txBusy falls.
REQ-040 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=100, owner drops reqValid after header -> abortPulse at stall cycle 100, state IDLE, frameCount unchanged; without the macro, the FSM stays in SEND_DATA.
REQ-041 Reset asserted in WAIT_DATA -> all outputs 0 immediately; after release, a req2-only request yields header 0xA2.
